dm_store_buffer: RTL and testbench

- Posted-store buffer between the M-stage memory-access logic and the word-addressed data memory (dm).
- Accepts byte-enabled stores from the pipeline and retires them to dm in program order.
- Read-modify-write makes each retired store a full-word dm write.
- Forwards pending store bytes to same-cycle loads, so the pipeline sees correct memory contents with zero load latency.

---
 rtl/dm_store_buffer.sv | 125 ++++++++++++
 tb/tb_dm_store_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_store_buffer.sv
// Posted-store buffer between the M-stage and the word-addressed data memory.
// Stores are queued in a circular FIFO and retired to dm in program order as
// full-word read-modify-write writes. Same-cycle loads see pending store bytes
// merged over the dm read data. A drain happens on every non-load cycle while
// the buffer holds a store.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_pc,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        empty,
  output logic [31:0] dm_addr,
  input  logic [31:0] dm_rdata,
  output logic        dm_we,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  // Entry storage; the word address keeps its upper bits so the dm write log
  // shows the address exactly as the pipeline issued it.
  logic [29:0] ent_addr [DEPTH];
  logic [31:0] ent_data [DEPTH];
  logic [3:0]  ent_be   [DEPTH];
  logic [31:0] ent_pc   [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic full;
  logic is_load;
  logic drain;
  logic enq;

  // Replace the byte lanes selected by be with the matching lanes of data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                              input logic [31:0] data,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  // Occupancy flags and the per-cycle decision: load, drain, enqueue, stall.
  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    is_load = req_valid & ~req_we;
    drain   = ~is_load & ~empty;
    enq     = req_valid & req_we & ~full;
    stall   = req_valid & req_we & full;
  end

  // Load forwarding: walk the live entries oldest to youngest so the youngest
  // matching store owns each byte lane.
  always_comb begin : fwd
    logic [PW-1:0] slot;
    logic [PW:0]   ofs;
    load_data = dm_rdata;
    slot      = '0;
    ofs       = '0;
    if (is_load) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot = head + PW'(i);
        ofs  = (PW+1)'(i);
        if ((ofs < count) && (ent_addr[slot][AW-1:0] == req_addr[AW+1:2])) begin
          load_data = merge_bytes(load_data, ent_data[slot], ent_be[slot]);
        end
      end
    end
  end

  // dm port: the head entry owns the port while draining, otherwise the
  // request address passes straight through.
  always_comb begin
    dm_we    = drain;
    dm_addr  = req_addr;
    dm_wdata = merge_bytes(dm_rdata, ent_data[head], ent_be[head]);
    dm_pc    = ent_pc[head];
    if (drain) dm_addr = {ent_addr[head], 2'b00};
  end

  // Pointer and occupancy state; reset discards everything still pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)   tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      case ({enq, drain})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload write at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= req_addr[31:2];
      ent_data[tail] <= req_wdata;
      ent_be[tail]   <= req_be;
      ent_pc[tail]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: a queue-based reference model predicts
// each cycle's outputs, and a monitor on the falling edge compares them.
module tb_dm_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 12;
  localparam int NW    = 1 << AW;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [31:0] req_pc;
  logic        stall;
  logic [31:0] load_data;
  logic        empty;
  logic [31:0] dm_addr;
  logic [31:0] dm_rdata;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic [31:0] dm_pc;

  always #5 clk = ~clk;

  dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .req_pc    (req_pc),
    .stall     (stall),
    .load_data (load_data),
    .empty     (empty),
    .dm_addr   (dm_addr),
    .dm_rdata  (dm_rdata),
    .dm_we     (dm_we),
    .dm_wdata  (dm_wdata),
    .dm_pc     (dm_pc)
  );

  // Data memory seen by the DUT (written only by the driver process).
  logic [31:0] dm_mem [NW];
  assign dm_rdata = dm_mem[dm_addr[AW+1:2]];

  // Reference model state.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } st_t;

  typedef struct {
    bit          chk;
    bit          is_load;
    logic        stall;
    logic        empty;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] ld;
  } exp_t;

  st_t         sq[$];
  exp_t        exp_q[$];
  logic [31:0] ref_mem [NW];
  bit          final_req = 1'b0;
  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;

  function automatic logic [31:0] merge(input logic [31:0] base, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: drive inputs, predict outputs, update model, commit dm write.
  task automatic step(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] pc, input bit rst,
                      input bit chk = 1'b1);
    exp_t e;
    st_t  h;
    st_t  n;
    bit   full;
    logic [31:0] w;
    @(posedge clk);
    #1;
    reset = rst; req_valid = v; req_we = we; req_addr = a;
    req_wdata = d; req_be = be; req_pc = pc;
    full      = (sq.size() == DEPTH);
    e.chk     = chk;
    e.is_load = v && !we;
    e.empty   = (sq.size() == 0);
    e.stall   = v && we && full;
    e.we      = !e.is_load && (sq.size() != 0);
    e.addr    = a;
    e.wdata   = '0;
    e.pc      = '0;
    e.ld      = '0;
    if (e.we) begin
      h       = sq[0];
      e.addr  = {h.addr[31:2], 2'b00};
      e.wdata = merge(ref_mem[h.addr[AW+1:2]], h.data, h.be);
      e.pc    = h.pc;
    end
    if (e.is_load) begin
      w = ref_mem[a[AW+1:2]];
      foreach (sq[k]) if (sq[k].addr[AW+1:2] == a[AW+1:2]) w = merge(w, sq[k].data, sq[k].be);
      e.ld = w;
    end
    exp_q.push_back(e);
    if (e.we) begin
      ref_mem[h.addr[AW+1:2]] = e.wdata;
      void'(sq.pop_front());
    end
    if (rst) sq.delete();
    else if (v && we && !full) begin
      n.addr = a; n.data = d; n.be = be; n.pc = pc;
      sq.push_back(n);
    end
    #7;
    if (dm_we === 1'b1) dm_mem[dm_addr[AW+1:2]] = dm_wdata;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] pc);
    step(1'b1, 1'b1, a, d, be, pc, 1'b0);
  endtask

  task automatic load(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  // Monitor: pop the prediction for this cycle and compare; finish on request.
  always @(negedge clk) begin
    exp_t e;
    int   bad;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        total++;
        if (stall !== e.stall) $display("FAIL stall cyc %0d: got %b expected %b", cyc, stall, e.stall);
        else passed++;
        total++;
        if (empty !== e.empty) $display("FAIL empty cyc %0d: got %b expected %b", cyc, empty, e.empty);
        else passed++;
        total++;
        if (dm_we !== e.we) $display("FAIL dm_we cyc %0d: got %b expected %b", cyc, dm_we, e.we);
        else passed++;
        total++;
        if (dm_addr !== e.addr) $display("FAIL dm_addr cyc %0d: got %h expected %h", cyc, dm_addr, e.addr);
        else passed++;
        if (e.we) begin
          total++;
          if (dm_wdata !== e.wdata) $display("FAIL dm_wdata cyc %0d: got %h expected %h", cyc, dm_wdata, e.wdata);
          else passed++;
          total++;
          if (dm_pc !== e.pc) $display("FAIL dm_pc cyc %0d: got %h expected %h", cyc, dm_pc, e.pc);
          else passed++;
        end
        if (e.is_load) begin
          total++;
          if (load_data !== e.ld) $display("FAIL load_data cyc %0d: got %h expected %h", cyc, load_data, e.ld);
          else passed++;
        end
      end
    end
    if (final_req && exp_q.size() == 0) begin
      bad = 0;
      for (int i = 0; i < NW; i++) if (dm_mem[i] !== ref_mem[i]) bad++;
      total++;
      if (bad != 0) $display("FAIL mem_final: %0d words differ, expected 0", bad);
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "timeout");
  end

  // Stimulus: directed scenarios followed by a randomized mix.
  initial begin
    logic [31:0] a;
    logic [31:0] w;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; req_pc = '0;
    for (int i = 0; i < NW; i++) begin
      w = $urandom;
      dm_mem[i] = w;
      ref_mem[i] = w;
    end
    dm_mem[8]  = 32'hCAFEF00D; ref_mem[8]  = 32'hCAFEF00D;
    dm_mem[12] = 32'h0;        ref_mem[12] = 32'h0;

    // Reset: first cycle has undefined state, second checks reset outputs.
    step(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1);

    // Full-word store then drain.
    store(32'h10, 32'h11223344, 4'hF, 32'h100);
    idle(); idle();

    // Byte store forwarded to an immediate load.
    store(32'h20, 32'h000000AB, 4'h1, 32'h104);
    load(32'h20);
    idle(); idle();

    // Two partial stores to one word, then loads of that word.
    store(32'h30, 32'h00001111, 4'h3, 32'h108);
    store(32'h30, 32'h00222200, 4'h6, 32'h10C);
    load(32'h30); load(32'h32);
    idle(); idle();

    // Reset while a store is pending: it must never reach dm.
    store(32'h40, 32'hDEADBEEF, 4'hF, 32'h110);
    step(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1);
    idle(); load(32'h40);

    // Wrap-around: interleaved store/idle pairs.
    for (int k = 0; k < 10; k++) begin
      store(32'h50 + 32'(4*k), $urandom, 4'($urandom), 32'h200 + 32'(4*k));
      idle();
    end
    idle();

    // Randomized mix over a small word pool with random upper address bits.
    for (int k = 0; k < 400; k++) begin
      a = $urandom;
      a[AW+1:2] = AW'(4 + $urandom_range(0, 7));
      step(($urandom % 4) != 0, $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom),
           $urandom, ($urandom % 40) == 0);
    end
    for (int k = 0; k < 4; k++) idle();
    final_req = 1'b1;
  end

endmodule
